// File: rtl/fcdt_pkg.sv
// Shared definitions for the 8x8 forward DCT: FSM encoding, widths,
// fixed-point cosine ROM and the output saturation helper.
package fcdt_pkg;

    localparam int COEF_W = 13;   // signed ROM word width
    localparam int FRAC   = 8;    // ROM scale is 2^FRAC
    localparam int T_W    = 22;   // transpose-buffer word width
    localparam int ACC_W  = 38;   // multiply-accumulate width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        FIN  = 2'd3
    } state_t;

    // C[r][k] = round(256 * a_r * cos((2k+1) r pi / 16)), row-major r*8+k
    localparam logic signed [COEF_W-1:0] C_TAB [64] = '{
        13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,   13'sd91,
        13'sd126,  13'sd106,  13'sd71,   13'sd25,  -13'sd25,  -13'sd71,  -13'sd106, -13'sd126,
        13'sd118,  13'sd49,  -13'sd49,  -13'sd118, -13'sd118, -13'sd49,   13'sd49,   13'sd118,
        13'sd106, -13'sd25,  -13'sd126, -13'sd71,   13'sd71,   13'sd126,  13'sd25,  -13'sd106,
        13'sd91,  -13'sd91,  -13'sd91,   13'sd91,   13'sd91,  -13'sd91,  -13'sd91,   13'sd91,
        13'sd71,  -13'sd126,  13'sd25,   13'sd106, -13'sd106, -13'sd25,   13'sd126, -13'sd71,
        13'sd49,  -13'sd118,  13'sd118, -13'sd49,  -13'sd49,   13'sd118, -13'sd118,  13'sd49,
        13'sd25,  -13'sd71,   13'sd106, -13'sd126,  13'sd126, -13'sd106,  13'sd71,  -13'sd25
    };

    // Clamp a shifted accumulator to the 16-bit signed coefficient range
    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > 38'sd32767)
            return 16'sh7FFF;
        else if (v < -38'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/fcdt_tbuf.sv
// 8x8 transpose buffer: synchronous single-entry write, combinational
// whole-row read. Holds no reset; contents are rewritten every pass 1.
module fcdt_tbuf
    import fcdt_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [2:0]       wr_row,
    input  logic [2:0]       wr_col,
    input  logic [T_W-1:0]   wr_data,
    input  logic [2:0]       rd_sel,
    output logic [8*T_W-1:0] rd_data
);

    logic [T_W-1:0] mem [8][8];

    // Write one intermediate value per cycle during the row pass
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_row][wr_col] <= wr_data;
    end

    // Present the selected row as one flat word, entry k at [T_W*k +: T_W]
    always_comb begin
        for (int unsigned k = 0; k < 8; k++)
            rd_data[T_W*k +: T_W] = mem[rd_sel][k];
    end

endmodule

// File: rtl/fcdt.sv
// 8x8 forward DCT. Pass 1 transforms image rows into the transpose buffer,
// pass 2 transforms its columns and streams one coefficient per cycle.
// A single eight-term MAC is shared by both passes via an operand mux.
module fcdt
    import fcdt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [63:0]        in_row,
    output logic [2:0]         rd_row,
    output logic signed [15:0] coef_out,
    output logic [2:0]         coef_i,
    output logic [2:0]         coef_j,
    output logic               coef_valid,
    output logic               busy,
    output logic               done
);

    state_t state, state_nxt;
    logic [2:0] i, j;
    logic last_idx;
    logic pass1, pass2;

    logic [8*T_W-1:0]        t_row;
    logic [8:0]              x_k  [8];
    logic signed [T_W-1:0]   op_a [8];
    logic signed [COEF_W-1:0] op_c [8];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;

    assign last_idx = (i == 3'd7) && (j == 3'd7);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start)    state_nxt = P1;
            P1:   if (last_idx) state_nxt = P2;
            P2:   if (last_idx) state_nxt = FIN;
            FIN:                state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs and pass selects
    always_comb begin
        pass1  = (state == P1);
        pass2  = (state == P2);
        busy   = (state != IDLE);
        rd_row = pass1 ? i : '0;
    end

    // Raster index counters; j inner, both wrap naturally at 3 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i <= '0;
            j <= '0;
        end else if (pass1 || pass2) begin
            j <= j + 3'd1;
            if (j == 3'd7)
                i <= i + 3'd1;
        end else begin
            i <= '0;
            j <= '0;
        end
    end

    fcdt_tbuf u_tbuf (
        .clk     (clk),
        .we      (pass1),
        .wr_row  (j),
        .wr_col  (i),
        .wr_data (shifted[T_W-1:0]),
        .rd_sel  (j),
        .rd_data (t_row)
    );

    // Operand select: pixels x ROM row j in pass 1, ROM row i x buffer row j in pass 2
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            x_k[k] = {1'b0, in_row[8*k +: 8]} - 9'd128;
            if (pass2) begin
                op_a[k] = $signed(t_row[T_W*k +: T_W]);
                op_c[k] = C_TAB[{i, 3'(k)}];
            end else begin
                op_a[k] = $signed({{(T_W-9){x_k[k][8]}}, x_k[k]});
                op_c[k] = C_TAB[{j, 3'(k)}];
            end
        end
    end

    // Eight-term multiply-accumulate followed by a flooring scale-down
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < 8; k++)
            acc = acc + $signed({{(ACC_W-T_W){op_a[k][T_W-1]}}, op_a[k]})
                      * $signed({{(ACC_W-COEF_W){op_c[k][COEF_W-1]}}, op_c[k]});
        shifted = acc >>> FRAC;
    end

    // Registered coefficient stream and end-of-transform pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_out   <= '0;
            coef_i     <= '0;
            coef_j     <= '0;
            coef_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            coef_valid <= pass2;
            done       <= (state == FIN);
            if (pass2) begin
                coef_out <= sat16(shifted);
                coef_i   <= i;
                coef_j   <= j;
            end
        end
    end

endmodule

// File: tb/tb_fcdt.sv
// Bench for fcdt: table of constant images with known DC results, a
// reference model for random/checkerboard images, and hand-written
// sequences for start-while-busy, back-to-back start and mid-pass reset.
module tb_fcdt;

    logic               clk;
    logic               rst;
    logic               start;
    logic [63:0]        in_row;
    logic [2:0]         rd_row;
    logic signed [15:0] coef_out;
    logic [2:0]         coef_i;
    logic [2:0]         coef_j;
    logic               coef_valid;
    logic               busy;
    logic               done;

    fcdt dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_row     (in_row),
        .rd_row     (rd_row),
        .coef_out   (coef_out),
        .coef_i     (coef_i),
        .coef_j     (coef_j),
        .coef_valid (coef_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] img [8];
    assign in_row = img[rd_row];

    typedef struct {
        int i;
        int j;
        int y;
    } exp_t;

    typedef struct {
        int pix;
        int y00;
    } vec_t;

    exp_t exp_q[$];
    exp_t ev;
    int   cm [8][8];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   nvalid, ndone, first_vc, done_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Cosine table derived from the defining formula, rounded to nearest
    task automatic init_cos();
        real a, v;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                a = (r == 0) ? $sqrt(1.0 / 8.0) : $sqrt(2.0 / 8.0);
                v = 256.0 * a * $cos((2.0 * k + 1.0) * r * 3.14159265358979 / 16.0);
                cm[r][k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
    endtask

    // Bit-accurate two-pass reference; pushes 64 raster-order expectations
    task automatic push_model();
        longint t [8][8];
        longint s, y;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += longint'(int'(img[i][8*k +: 8]) - 128) * cm[j][k];
                t[i][j] = s >>> 8;
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += longint'(cm[i][k]) * t[k][j];
                y = s >>> 8;
                if (y > 32767)  y = 32767;
                if (y < -32768) y = -32768;
                exp_q.push_back('{i, j, int'(y)});
            end
    endtask

    task automatic fill_const(input int pix);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++)
                img[r][8*k +: 8] = 8'(pix);
    endtask

    task automatic clear_counts();
        nvalid   = 0;
        ndone    = 0;
        first_vc = -1;
        done_c   = -1;
    endtask

    // Output monitor: pop the scoreboard on every valid coefficient
    always @(negedge clk) begin
        if (!rst) begin
            if (coef_valid) begin
                if (first_vc < 0) first_vc = cyc;
                nvalid++;
                if (exp_q.size() == 0)
                    check("spurious_valid", coef_valid, 0);
                else begin
                    ev = exp_q.pop_front();
                    check("coef_out", int'(coef_out), ev.y);
                    check("coef_i", coef_i, ev.i);
                    check("coef_j", coef_j, ev.j);
                end
            end
            if (done) begin
                ndone++;
                done_c = cyc;
            end
        end
    end

    // One transform with timing checks; inject=1 pulses start at P2 cycle 10
    task automatic run_xform(input int inject);
        int e;
        clear_counts();
        @(negedge clk); start = 1'b1;
        @(negedge clk); e = cyc; start = 1'b0;
        for (int n = 0; n < 300 && ndone == 0; n++) begin
            @(negedge clk);
            start = (inject == 1 && cyc == e + 74);
            if (cyc == e + 10) begin
                check("busy_p1", busy, 1);
                check("rd_row_p1", rd_row, 1);
            end
            if (cyc == e + 70) begin
                check("busy_p2", busy, 1);
                check("rd_row_p2", rd_row, 0);
            end
        end
        start = 1'b0;
        repeat ((inject == 1) ? 140 : 4) @(negedge clk);
        check("nvalid", nvalid, 64);
        check("ndone", ndone, 1);
        check("first_valid_lat", first_vc - e, 65);
        check("done_lat", done_c - e, 129);
        check("queue_left", exp_q.size(), 0);
        check("busy_idle", busy, 0);
        check("rd_row_idle", rd_row, 0);
    endtask

    vec_t vecs [5];

    initial begin
        int e;
        vecs[0] = '{128, 0};
        vecs[1] = '{255, 1026};
        vecs[2] = '{0, -1036};
        vecs[3] = '{129, 5};
        vecs[4] = '{127, -9};

        rst   = 1'b1;
        start = 1'b0;
        fill_const(128);
        init_cos();
        clear_counts();

        repeat (2) @(negedge clk);
        check("rst_rd_row", rd_row, 0);
        check("rst_coef_out", coef_out, 0);
        check("rst_coef_i", coef_i, 0);
        check("rst_coef_j", coef_j, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Constant images: only the DC term is non-zero
        for (int v = 0; v < 5; v++) begin
            fill_const(vecs[v].pix);
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    exp_q.push_back('{i, j, (i == 0 && j == 0) ? vecs[v].y00 : 0});
            run_xform(0);
        end

        // Random image against the reference model
        for (int r = 0; r < 8; r++) img[r] = {$urandom, $urandom};
        push_model();
        run_xform(0);

        // start pulsed mid-P2 must be ignored
        for (int r = 0; r < 8; r++) img[r] = {$urandom, $urandom};
        push_model();
        run_xform(1);

        // start held from P2 through FIN: second transform follows immediately
        clear_counts();
        push_model();
        push_model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); e = cyc; start = 1'b0;
        for (int n = 0; n < 400 && ndone < 2; n++) begin
            @(negedge clk);
            if (cyc == e + 100) start = 1'b1;
            if (cyc == e + 129) check("b2b_idle_gap", busy, 0);
            if (cyc == e + 130) check("b2b_restart", busy, 1);
            if (cyc == e + 131) start = 1'b0;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_nvalid", nvalid, 128);
        check("b2b_ndone", ndone, 2);
        check("b2b_first_lat", first_vc - e, 65);
        check("b2b_done_lat", done_c - e, 259);
        check("b2b_queue_left", exp_q.size(), 0);

        // Reset during P1 aborts the transform
        clear_counts();
        for (int r = 0; r < 8; r++) img[r] = {$urandom, $urandom};
        push_model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); e = cyc; start = 1'b0;
        for (int n = 0; n < 40 && cyc < e + 30; n++) @(negedge clk);
        check("abort_rd_row_pre", rd_row, 3);
        rst = 1'b1;
        #1;
        check("abort_rd_row", rd_row, 0);
        check("abort_coef_out", coef_out, 0);
        check("abort_coef_i", coef_i, 0);
        check("abort_coef_j", coef_j, 0);
        check("abort_coef_valid", coef_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_counts();
        repeat (150) @(negedge clk);
        check("abort_nvalid", nvalid, 0);
        check("abort_ndone", ndone, 0);
        check("abort_busy_after", busy, 0);

        // Checkerboard 0/255 after the aborted run
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++)
                img[r][8*k +: 8] = ((r + k) % 2 == 1) ? 8'd255 : 8'd0;
        push_model();
        run_xform(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcdt.md
FCDT -- requirements
Module: fcdt

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled in IDLE; begins one 8x8 forward transform.
- in_row  in  64  pixel row from image memory, 8 unsigned 8-bit pixels; pixel k at bits [8k+7:8k]; combinational read valid in the same cycle as rd_row.
- rd_row  out  3  image-memory row address.
- coef_out  out  16  signed DCT coefficient Y[i][j], registered.
- coef_i  out  3  row index of coef_out.
- coef_j  out  3  column index of coef_out.
- coef_valid  out  1  coef_out, coef_i and coef_j are valid this cycle; one coefficient per cycle.
- busy  out  1  high from the P1 entry cycle through the final coef_valid cycle.
- done  out  1  one-cycle pulse, one cycle after the last coef_valid.
REQ-002 Parameter COEF_W = 13 (signed ROM width); parameter FRAC = 8 (ROM scale 2^FRAC).

Function
REQ-003 FSM states: IDLE, P1, P2, FIN.
- IDLE->P1 on start=1.
- P1->P2 after index (i,j)=(7,7).
- P2->FIN after (7,7).
- FIN->IDLE unconditionally.
REQ-004 Counters: j increments every cycle in P1/P2 and wraps 7->0; i increments when j=7 and wraps 7->0; both are 0 on entry to P1 and to P2.
REQ-005 ROM C[r][k] = round(256 * a_r * cos((2k+1)*r*pi/16)), with a_0 = sqrt(1/8) and a_r = sqrt(2/8) otherwise; C[0][k] = 91.
REQ-006 Level shift: x_k = in_row pixel k minus 128, as signed 9-bit.
REQ-007 P1 cycle (i,j): rd_row = i; T = (sum_k x_k * C[j][k]) >>> FRAC, arithmetic shift, flooring; the 22-bit signed result is written to transpose buffer entry [j][i].
REQ-008 P2 cycle (i,j): Y = (sum_k C[i][k] * Tbuf[j][k]) >>> FRAC; accumulate at 38 bits minimum; saturate to [-32768, 32767].
REQ-009 Y from P2 cycle (i,j) SHALL appear on coef_out/coef_i/coef_j with coef_valid=1 in the next cycle; latency is 1.
REQ-010 Coefficient order is raster (i outer, j inner); exactly 64 coef_valid pulses per transform.
REQ-011 Timing of one transform:
- start accepted at edge E;
- P1 occupies cycles E+1..E+64;
- P2 occupies E+65..E+128;
- coef_valid is high in E+66..E+129;
- done pulses at E+130.
REQ-012 start is ignored while busy=1 or in FIN.
REQ-013 If start=1 in IDLE on the same cycle that FIN returns, the transform begins on the following edge.
REQ-014 rd_row is 0 outside P1; external memory contents outside P1 are don't-care.
REQ-015 The transpose buffer is written only in P1 and read only in P2; no read-during-write hazard exists.

Reset
REQ-016 rst=1 SHALL immediately force state IDLE, i=j=0, and all outputs (rd_row, coef_out, coef_i, coef_j, coef_valid, busy, done) to 0.
REQ-017 A reset during P1/P2 aborts the transform: no further coef_valid, no done; transpose buffer contents become don't-care.
REQ-018 The transpose buffer SHALL NOT require reset.

Structure
REQ-019 A shared package SHALL hold:
- state encoding (2 bits: IDLE=0, P1=1, P2=2, FIN=3);
- COEF_W, FRAC;
- the 64-entry C table constant.
REQ-020 One sub-module: fcdt_tbuf, an 8x8x22-bit transpose buffer.
- Write port: row/column address, synchronous.
- Read port: whole row, 176 bits, combinational.
REQ-021 The C ROM and the eight-term multiply-accumulate SHALL be inline and shared between P1 and P2 through a pass-select mux.

Verification
REQ-022 Scenarios the bench SHALL cover:
- All pixels 128 -> all 64 coef_out = 0; coef_valid high 64 cycles; done at E+130.
- All pixels 255 -> Y[0][0] = 1026, every other coefficient = 0.
- All pixels 0 -> Y[0][0] = -1036, every other coefficient = 0.
- Random image -> every coefficient matches a bit-accurate reference model (floor shifts, REQ-005 table), in raster order with correct coef_i/coef_j.
- start pulsed at P2 cycle 10 -> ignored: still exactly 64 coef_valid and one done; a start held high through FIN -> second transform starts per REQ-013.
- rst asserted at P1 cycle 30 -> all outputs 0 immediately, no done; a new start then yields correct results for a checkerboard image (0/255).
